// File: rtl/uart_rx_sample_gen.sv
// Bit timing and 3-point majority sampling for the UART receiver.
// Runtime divisor (loadable only while idle); flags false start, frame end and stop errors.
module uart_rx_sample_gen #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD_DEFAULT = 115200,
   parameter int DIV_W        = 16,
   parameter int SPREAD       = 4,
   parameter int FRAME_BITS   = 10
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             rxd_sync,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic [DIV_W-1:0] div_cur,
   output logic             sample_stb,
   output logic             sample_bit,
   output logic [3:0]       bit_idx,
   output logic             start_err,
   output logic             frame_done,
   output logic             stop_err
);

   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'((CLK_HZ + BAUD_DEFAULT / 2) / BAUD_DEFAULT);
   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2 * SPREAD + 2);
   localparam logic [DIV_W-1:0] SPR      = DIV_W'(SPREAD);
   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
   localparam logic [3:0]       LAST_IDX = 4'(FRAME_BITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] mid;
   logic             cap_lo, cap_mid;
   logic             vote;

   assign mid  = div_cur >> 1;
   // Third capture is taken straight from the pin on the strobe-registering edge.
   assign vote = (cap_lo & cap_mid) | (cap_lo & rxd_sync) | (cap_mid & rxd_sync);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         cap_lo     <= 1'b0;
         cap_mid    <= 1'b0;
         div_cur    <= DIV_RST;
         sample_stb <= 1'b0;
         sample_bit <= 1'b0;
         start_err  <= 1'b0;
         frame_done <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         start_err  <= 1'b0;
         frame_done <= 1'b0;
         stop_err   <= 1'b0;

         if (div_load && state == IDLE)
            div_cur <= (div_in < DIV_MIN) ? DIV_MIN : div_in;

         // Dropping en aborts from any state and beats a strobe due on this edge.
         if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            cap_lo  <= 1'b0;
            cap_mid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= RUN;
                  cnt     <= '0;
                  bit_idx <= '0;
               end
               RUN: begin
                  if (cnt == div_cur - ONE) begin
                     cnt <= '0;
                     if (bit_idx != LAST_IDX) bit_idx <= bit_idx + 4'd1;
                  end else begin
                     cnt <= cnt + ONE;
                  end

                  if (cnt == mid - SPR) cap_lo  <= rxd_sync;
                  if (cnt == mid)       cap_mid <= rxd_sync;

                  if (cnt == mid + SPR) begin
                     sample_stb <= 1'b1;
                     sample_bit <= vote;
                     if (bit_idx == 4'd0 && vote) begin
                        start_err <= 1'b1;
                        state     <= HALT;
                     end
                     if (bit_idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        stop_err   <= !vote;
                        state      <= HALT;
                     end
                  end
               end
               HALT: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sample_gen.sv
// Randomised frame bench: expected strobe times and votes come from bit-period arithmetic.
module tb_uart_rx_sample_gen;
   localparam int SP      = 4;
   localparam int DIV_RST = 434;
   localparam int DIV_MIN = 10;

   logic        sys_clk = 1'b0;
   logic        rst_n, en, rxd_sync, div_load;
   logic [15:0] div_in, div_cur;
   logic        sample_stb, sample_bit, start_err, frame_done, stop_err;
   logic [3:0]  bit_idx;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_div = DIV_RST;

   always #5 sys_clk = ~sys_clk;

   uart_rx_sample_gen dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .en         (en),
      .rxd_sync   (rxd_sync),
      .div_in     (div_in),
      .div_load   (div_load),
      .div_cur    (div_cur),
      .sample_stb (sample_stb),
      .sample_bit (sample_bit),
      .bit_idx    (bit_idx),
      .start_err  (start_err),
      .frame_done (frame_done),
      .stop_err   (stop_err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Line level in cycle t after RUN entry: frame bit t/div, idle high after, optional inversions.
   function automatic logic wave(input int t, input int div, input logic [9:0] bits,
                                 input int g0, input int g1);
      logic v;
      int   b;
      b = t / div;
      v = (b < 10) ? bits[b] : 1'b1;
      if (t == g0 || t == g1) v = ~v;
      return v;
   endfunction

   task automatic run_frame(input string tag, input int ld, input logic [9:0] bits,
                            input int g0, input int g1, input int abort_t, input int ncyc);
      int div, mid, ts, v, s;
      int et[$], eb[$], ei[$], ef[$];
      int gt[$], gb[$], gi[$], gf[$];
      int stray;
      stray = 0;
      if (ld != 0) exp_div = (ld < DIV_MIN) ? DIV_MIN : ld;
      div = exp_div;
      mid = div / 2;
      for (int b = 0; b < 10; b++) begin
         ts = b * div + mid + SP + 1;
         if ((abort_t >= 0 && ts > abort_t) || ts >= ncyc) break;
         s = int'(wave(b*div + mid - SP, div, bits, g0, g1)) + int'(wave(b*div + mid, div, bits, g0, g1))
           + int'(wave(b*div + mid + SP, div, bits, g0, g1));
         v = (s >= 2) ? 1 : 0;
         et.push_back(ts);
         eb.push_back(v);
         ei.push_back((ts / div > 9) ? 9 : ts / div);
         ef.push_back(((b == 0 && v == 1) ? 4 : 0) + ((b == 9) ? 2 : 0) + ((b == 9 && v == 0) ? 1 : 0));
         if ((b == 0 && v == 1) || b == 9) break;
      end

      en = 1'b1; div_load = (ld != 0); div_in = 16'(ld);
      @(posedge sys_clk); #1;
      div_load = 1'b0;
      chk({tag, " div_cur"}, int'(div_cur), div);
      for (int t = 0; t < ncyc; t++) begin
         if (abort_t >= 0 && t >= abort_t) en = 1'b0;
         rxd_sync = wave(t, div, bits, g0, g1);
         @(negedge sys_clk);
         if (sample_stb) begin
            gt.push_back(t);
            gb.push_back(int'(sample_bit));
            gi.push_back(int'(bit_idx));
            gf.push_back(int'({start_err, frame_done, stop_err}));
         end else if (start_err || frame_done || stop_err) begin
            stray++;
         end
         if (abort_t >= 0 && t == abort_t + 1) chk({tag, " bit_idx after abort"}, int'(bit_idx), 0);
         @(posedge sys_clk); #1;
      end
      en = 1'b0; rxd_sync = 1'b1;
      @(posedge sys_clk); #1;

      chk({tag, " strobe count"}, gt.size(), et.size());
      for (int i = 0; i < et.size() && i < gt.size(); i++) begin
         chk($sformatf("%s stb%0d time", tag, i), gt[i], et[i]);
         chk($sformatf("%s stb%0d bit", tag, i), gb[i], eb[i]);
         chk($sformatf("%s stb%0d idx", tag, i), gi[i], ei[i]);
         chk($sformatf("%s stb%0d {start,done,stop}", tag, i), gf[i], ef[i]);
      end
      chk({tag, " flags outside strobe"}, stray, 0);
   endtask

   task automatic idle_load(input string tag, input int val);
      div_in = 16'(val); div_load = 1'b1;
      @(posedge sys_clk); #1;
      div_load = 1'b0;
      exp_div = (val < DIV_MIN) ? DIV_MIN : val;
      chk(tag, int'(div_cur), exp_div);
   endtask

   initial begin
      logic [9:0] f55;
      int ld, div;
      f55 = {1'b1, 8'h55, 1'b0};
      rst_n = 1'b0; en = 1'b0; rxd_sync = 1'b1; div_load = 1'b0; div_in = '0;
      #12;
      chk("rst div_cur", int'(div_cur), DIV_RST);
      chk("rst outputs", int'({sample_stb, sample_bit, bit_idx, start_err, frame_done, stop_err}), 0);
      rst_n = 1'b1;
      @(posedge sys_clk); #1;

      run_frame("f55", 0, f55, -1, -1, -1, 4200);
      run_frame("div27", 27, {1'b1, 8'hA3, 1'b0}, -1, -1, -1, 300);
      run_frame("glitch1", 0, {1'b1, 8'h0F, 1'b0}, 2*27 + 9, 5*27 + 17, -1, 300);
      run_frame("glitch2", 0, {1'b1, 8'h0F, 1'b0}, 3*27 + 9, 3*27 + 13, -1, 300);
      idle_load("clamp div 5", 5);
      run_frame("div10", 0, {1'b1, 8'h96, 1'b0}, -1, -1, -1, 150);

      en = 1'b1;
      repeat (6) @(posedge sys_clk);
      #1; div_in = 16'd50; div_load = 1'b1;
      @(posedge sys_clk); #1;
      div_load = 1'b0;
      chk("load in RUN ignored", int'(div_cur), exp_div);
      en = 1'b0;
      @(posedge sys_clk); #1;

      idle_load("load 434", 434);
      run_frame("false start", 0, {1'b1, 8'h00, 1'b1}, -1, -1, -1, 1200);
      run_frame("stop err", 0, {1'b0, 8'hC3, 1'b0}, -1, -1, -1, 4200);
      run_frame("abort", 0, f55, -1, -1, 3*434 + 100, 1600);
      run_frame("after abort", 0, f55, -1, -1, -1, 700);

      idle_load("load 60", 60);
      en = 1'b1;
      repeat (100) @(posedge sys_clk);
      #1; rst_n = 1'b0;
      #2;
      chk("mid rst div_cur", int'(div_cur), DIV_RST);
      chk("mid rst outputs", int'({sample_stb, bit_idx, start_err, frame_done, stop_err}), 0);
      exp_div = DIV_RST;
      en = 1'b0;
      #3; rst_n = 1'b1;
      @(posedge sys_clk); #1;
      run_frame("after rst", 0, f55, -1, -1, -1, 700);

      repeat (8) begin
         ld  = $urandom_range(60, 3);
         div = (ld < DIV_MIN) ? DIV_MIN : ld;
         run_frame($sformatf("rand div%0d", div), ld, {1'b1, 8'($urandom), 1'b0},
                   $urandom_range(10*div - 1, 0), $urandom_range(10*div - 1, 0), -1, 10*div + 20);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_sample_gen.md
# uart_rx_sample_gen

Parametrised bit-timing and sampling engine for the UART receiver; the successor to the fixed 115200-baud sample-clock counter. While the RX control FSM holds `en` high, the block times each bit with a runtime-loadable divisor. It takes a 3-point majority vote around mid-bit, tracks the bit index, and flags false starts, frame completion and stop-bit errors. It sits between the `rxd` synchroniser and the RX shift/control logic.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz
- `BAUD_DEFAULT`, 115200, baud rate used to compute the reset divisor
- `DIV_W`, 16, divisor and counter width
- `SPREAD`, 4, cycles between adjacent vote samples
- `FRAME_BITS`, 10, bits per frame including start and stop (index 0 = start, FRAME_BITS-1 = stop)
- `sys_clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  frame active, driven by the RX FSM
- `rxd_sync`  in  1  serial input, already synchronised to `sys_clk`
- `div_in`  in  DIV_W  new divisor value, in clocks per bit
- `div_load`  in  1  one-cycle load strobe for `div_in`
- `div_cur`  out  DIV_W  divisor currently in effect
- `sample_stb`  out  1  one-cycle pulse: `sample_bit` and `bit_idx` are valid
- `sample_bit`  out  1  majority-voted bit value
- `bit_idx`  out  4  index of the bit being timed or sampled
- `start_err`  out  1  one-cycle pulse: start bit sampled high (false start)
- `frame_done`  out  1  one-cycle pulse coincident with the stop-bit `sample_stb`
- `stop_err`  out  1  one-cycle pulse with `frame_done` when the stop bit is sampled low

## Operation
- **Reset values.**
  - `div_cur` = DIV_RST = (CLK_HZ + BAUD_DEFAULT/2) / BAUD_DEFAULT, which is 434 at the defaults.
  - All other outputs = 0. Internal `cnt` = 0. State = IDLE.
  - DIV_MIN = 2*SPREAD + 2, which is 10 at the defaults.
- **Divisor load.**
  - Accepted only in IDLE.
  - `div_cur` <= max(`div_in`, DIV_MIN) on the next edge.
  - A `div_load` in RUN or HALT is dropped; `div_cur` is unchanged.
- **States.**
  - IDLE: `cnt` = 0, `bit_idx` = 0, no strobes. Moves to RUN on an edge with `en` = 1.
  - RUN: counts and samples.
  - HALT: entered after `start_err` or `frame_done`. Counter frozen, no strobes. Moves to IDLE on an edge with `en` = 0.
  - Any state moves to IDLE on an edge with `en` = 0 (abort mid-frame), clearing `cnt`, `bit_idx` and the vote registers.
- **RUN counting.**
  - `cnt` increments by 1 per clock.
  - At `cnt` == `div_cur`-1, `cnt` wraps to 0 and `bit_idx` increments.
  - `bit_idx` never exceeds FRAME_BITS-1.
- **Sampling.**
  - MID = `div_cur` >> 1 (floor).
  - `rxd_sync` is captured on the edges where `cnt` == MID-SPREAD, MID and MID+SPREAD.
  - `sample_bit` = majority of the 3 captures, registered together with `sample_stb` on the edge after the MID+SPREAD capture.
- **Start check.**
  - If `bit_idx` = 0 and the vote = 1: `start_err` = 1 with `sample_stb`, then HALT.
- **Stop check.**
  - If `bit_idx` = FRAME_BITS-1: `frame_done` = 1 with `sample_stb`, and `stop_err` = !`sample_bit`, then HALT.
  - No further `sample_stb` until the block has passed through IDLE.
- **Width.** `cnt` is DIV_W bits and cannot overflow, because `div_cur` ≤ 2^DIV_W-1.

## Timing
- The edge on which IDLE→RUN occurs leaves `cnt` = 0. `cnt` = k holds for the cycle starting k edges later.
- `sample_stb` is high during the cycle where `cnt` == MID+SPREAD+1.
  - At `div_cur` = 434: captures at `cnt` = 213, 217, 221; strobe during `cnt` = 222.
  - First strobe is 222 cycles after the RUN-entry edge.
  - Successive strobes are exactly `div_cur` cycles apart.
- `frame_done` at the defaults comes (FRAME_BITS-1)*434 + 222 = 4128 cycles after RUN entry.
- If `en` falls in the same cycle a strobe would register, the abort wins: no strobe.
- A `div_load` in the same cycle `en` rises is accepted. The new divisor takes effect from that edge, so the first bit already uses it.
- Asserting `rst_n` mid-frame returns all outputs to their reset values immediately (asynchronous), including `div_cur` → DIV_RST.

## Test plan
- Reset, then a clean 0x55 frame at the default divisor (434 clocks per bit):
  - 10 `sample_stb` pulses, 434 cycles apart, first at 222.
  - `sample_bit` = 0,1,0,1,0,1,0,1,0,1.
  - `frame_done` = 1 on strobe 10, `stop_err` = 0.
- `div_in` = 27 with `div_load` in IDLE:
  - `div_cur` = 27; strobes every 27 cycles with MID = 13, first at cycle 18.
  - Then `div_in` = 5 → `div_cur` = 10 (clamped to DIV_MIN).
  - A load during RUN → `div_cur` unchanged.
- Glitch tolerance:
  - One-cycle inversions of `rxd_sync` at the MID-SPREAD capture point → `sample_bit` unchanged.
  - Inversions at two of the three capture points → `sample_bit` flips.
- False start: `rxd_sync` held 1 in bit 0 → `start_err` + `sample_stb` at cycle 222, then no strobes until `en` toggles low/high.
- Stop error: stop bit driven 0 → `frame_done` = 1 and `stop_err` = 1 on the same cycle.
- Abort:
  - `en` dropped at `cnt` = 100 of bit 3 → `bit_idx` = 0, no strobe.
  - Re-enable → fresh timing with the first strobe at 222.
  - Same check with `rst_n` pulsed mid-frame, which also restores `div_cur` = 434.
